// File: rtl/zircon_avalon_pwm_capture_logic.sv
`default_nettype none
// ============================================================================
// Module : zircon_avalon_pwm_capture_logic
// Brief  : Measures period and high time of an external PWM pin in csi_clk
//          cycles, with sticky no-edge timeout and sample counter.
// Rev    : 1.0  initial release
// ============================================================================
module zircon_avalon_pwm_capture_logic #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic        coe_pwm_in,
    input  logic        cap_enable,
    input  logic        cap_clear,
    input  logic [31:0] cap_timeout,
    output logic [31:0] cap_period,
    output logic [31:0] cap_high,
    output logic        cap_valid,
    output logic        cap_timeout_flag,
    output logic [15:0] cap_sample_cnt
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_WAIT_RISE = 2'd1;
    localparam logic [1:0]  c_MEAS_HIGH = 2'd2;
    localparam logic [1:0]  c_MEAS_LOW  = 2'd3;
    localparam logic [31:0] c_CNT_MAX   = 32'hFFFF_FFFF;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_next;
    logic [31:0] w_cnt_inc;
    logic [31:0] r_high_lat;
    logic [31:0] w_high_lat_next;
    logic [31:0] r_period;
    logic [31:0] w_period_next;
    logic [31:0] r_high;
    logic [31:0] w_high_next;
    logic        r_valid;
    logic        w_valid_next;
    logic        r_flag;
    logic        w_flag_next;
    logic [15:0] r_sample_cnt;
    logic [15:0] w_sample_cnt_next;
    logic        w_timeout_hit;

    // Zero-initialised chain so a pin already high at reset release looks like a rise later, not garbage.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], coe_pwm_in};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_sync_d;
    assign w_fall = ~w_sync & r_sync_d;
    assign w_edge = w_rise | w_fall;

    assign w_cnt_inc     = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + 32'd1;
    assign w_timeout_hit = (cap_timeout != 32'd0) && (r_cnt == cap_timeout) && !w_edge;

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_high_lat_next   = r_high_lat;
        w_period_next     = r_period;
        w_high_next       = r_high;
        w_valid_next      = 1'b0;
        w_flag_next       = r_flag;
        w_sample_cnt_next = r_sample_cnt;

        if (cap_clear) begin
            w_period_next     = 32'd0;
            w_high_next       = 32'd0;
            w_sample_cnt_next = 16'd0;
            w_flag_next       = 1'b0;
            w_cnt_next        = 32'd0;
            w_high_lat_next   = 32'd0;
            w_state_next      = cap_enable ? c_WAIT_RISE : c_IDLE;
        end else if (!cap_enable) begin
            w_state_next    = c_IDLE;
            w_cnt_next      = 32'd0;
            w_high_lat_next = 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_cnt_next   = 32'd0;
                    w_state_next = c_WAIT_RISE;
                end
                c_WAIT_RISE: begin
                    if (w_rise) begin
                        w_cnt_next   = 32'd1;
                        w_state_next = c_MEAS_HIGH;
                    end else begin
                        w_cnt_next   = 32'd0;
                    end
                end
                c_MEAS_HIGH: begin
                    w_cnt_next = w_rise ? 32'd1 : w_cnt_inc;
                    if (w_fall) begin
                        w_high_lat_next = r_cnt;
                        w_state_next    = c_MEAS_LOW;
                    end else if (w_timeout_hit) begin
                        w_flag_next  = 1'b1;
                        w_cnt_next   = 32'd0;
                        w_state_next = c_WAIT_RISE;
                    end
                end
                c_MEAS_LOW: begin
                    // Counter holds rise-to-now, so on the closing rise it is exactly the period.
                    if (w_rise) begin
                        w_period_next     = r_cnt;
                        w_high_next       = r_high_lat;
                        w_valid_next      = 1'b1;
                        w_sample_cnt_next = r_sample_cnt + 16'd1;
                        w_cnt_next        = 32'd1;
                        w_state_next      = c_MEAS_HIGH;
                    end else if (w_timeout_hit) begin
                        w_flag_next  = 1'b1;
                        w_cnt_next   = 32'd0;
                        w_state_next = c_WAIT_RISE;
                    end else begin
                        w_cnt_next   = w_cnt_inc;
                    end
                end
                default: begin
                    w_cnt_next   = 32'd0;
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_cnt        <= 32'd0;
            r_high_lat   <= 32'd0;
            r_period     <= 32'd0;
            r_high       <= 32'd0;
            r_valid      <= 1'b0;
            r_flag       <= 1'b0;
            r_sample_cnt <= 16'd0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_high_lat   <= w_high_lat_next;
            r_period     <= w_period_next;
            r_high       <= w_high_next;
            r_valid      <= w_valid_next;
            r_flag       <= w_flag_next;
            r_sample_cnt <= w_sample_cnt_next;
        end
    end

    assign cap_period       = r_period;
    assign cap_high         = r_high;
    assign cap_valid        = r_valid;
    assign cap_timeout_flag = r_flag;
    assign cap_sample_cnt   = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_zircon_avalon_pwm_capture_logic.sv
`default_nettype none
// ============================================================================
// Module : tb_zircon_avalon_pwm_capture_logic
// Brief  : Directed and randomized PWM stimulus against an edge-timestamp model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_zircon_avalon_pwm_capture_logic;

    localparam int c_SYNC = 2;

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n;
    logic        coe_pwm_in;
    logic        cap_enable;
    logic        cap_clear;
    logic [31:0] cap_timeout;
    logic [31:0] cap_period;
    logic [31:0] cap_high;
    logic        cap_valid;
    logic        cap_timeout_flag;
    logic [15:0] cap_sample_cnt;

    always #5 csi_clk = ~csi_clk;

    zircon_avalon_pwm_capture_logic #(
        .SYNC_STAGES(c_SYNC)
    ) u_dut (
        .csi_clk          (csi_clk),
        .rsi_reset_n      (rsi_reset_n),
        .coe_pwm_in       (coe_pwm_in),
        .cap_enable       (cap_enable),
        .cap_clear        (cap_clear),
        .cap_timeout      (cap_timeout),
        .cap_period       (cap_period),
        .cap_high         (cap_high),
        .cap_valid        (cap_valid),
        .cap_timeout_flag (cap_timeout_flag),
        .cap_sample_cnt   (cap_sample_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_valid_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: pin history delayed by the synchronizer depth, measurements from edge timestamps.
    logic [c_SYNC:0] m_hist;
    logic            m_rise;
    logic            m_fall;
    int              m_mode;       // 0 disarmed, 1 waiting for first rise, 2 measuring
    longint          m_now = 0;
    longint          m_last_rise;
    logic            m_in_low;
    logic [31:0]     m_high_lat;
    logic [31:0]     m_period;
    logic [31:0]     m_high;
    logic            m_valid;
    logic            m_flag;
    logic [15:0]     m_cnt;

    assign m_rise = m_hist[c_SYNC-1] & ~m_hist[c_SYNC];
    assign m_fall = ~m_hist[c_SYNC-1] & m_hist[c_SYNC];

    always @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            m_hist      <= '0;
            m_mode      <= 0;
            m_last_rise <= 0;
            m_in_low    <= 1'b0;
            m_high_lat  <= '0;
            m_period    <= '0;
            m_high      <= '0;
            m_valid     <= 1'b0;
            m_flag      <= 1'b0;
            m_cnt       <= '0;
        end else begin
            m_now   <= m_now + 1;
            m_hist  <= {m_hist[c_SYNC-1:0], coe_pwm_in};
            m_valid <= 1'b0;
            if (cap_clear) begin
                m_period <= '0;
                m_high   <= '0;
                m_cnt    <= '0;
                m_flag   <= 1'b0;
                m_mode   <= cap_enable ? 1 : 0;
            end else if (!cap_enable) begin
                m_mode <= 0;
            end else if (m_mode == 0) begin
                m_mode <= 1;
            end else if (m_mode == 1) begin
                if (m_rise) begin
                    m_mode      <= 2;
                    m_last_rise <= m_now;
                    m_in_low    <= 1'b0;
                end
            end else begin
                if (!m_in_low && m_fall) begin
                    m_high_lat <= 32'(m_now - m_last_rise);
                    m_in_low   <= 1'b1;
                end else if (m_in_low && m_rise) begin
                    m_period    <= 32'(m_now - m_last_rise);
                    m_high      <= m_high_lat;
                    m_valid     <= 1'b1;
                    m_cnt       <= m_cnt + 16'd1;
                    m_last_rise <= m_now;
                    m_in_low    <= 1'b0;
                end else if (!m_rise && !m_fall && cap_timeout != 0 &&
                             (m_now - m_last_rise) == longint'(cap_timeout)) begin
                    m_flag <= 1'b1;
                    m_mode <= 1;
                end
            end
        end
    end

    always @(negedge csi_clk) begin
        check_val("cyc_period", cap_period, m_period);
        check_val("cyc_high", cap_high, m_high);
        check_val("cyc_valid", 32'(cap_valid), 32'(m_valid));
        check_val("cyc_flag", 32'(cap_timeout_flag), 32'(m_flag));
        check_val("cyc_cnt", 32'(cap_sample_cnt), 32'(m_cnt));
        if (cap_valid === 1'b1) n_valid_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge csi_clk);
    endtask

    task automatic pwm(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            coe_pwm_in = 1'b1;
            tick(h);
            coe_pwm_in = 1'b0;
            tick(p - h);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] per, input logic [31:0] hi,
                                 input logic [31:0] cnt, input logic [31:0] flag);
        check_val({tag, "_period"}, cap_period, per);
        check_val({tag, "_high"}, cap_high, hi);
        check_val({tag, "_cnt"}, 32'(cap_sample_cnt), cnt);
        check_val({tag, "_flag"}, 32'(cap_timeout_flag), flag);
    endtask

    int v0;

    initial begin
        rsi_reset_n = 1'b0;
        coe_pwm_in  = 1'b0;
        cap_enable  = 1'b0;
        cap_clear   = 1'b0;
        cap_timeout = 32'd0;
        tick(3);
        #2;
        check_outputs("reset", 0, 0, 0, 0);
        check_val("reset_valid", 32'(cap_valid), 0);
        rsi_reset_n = 1'b1;
        cap_enable  = 1'b1;
        tick(5);

        // Steady 100/30: five rises give four samples.
        v0 = n_valid_seen;
        pwm(100, 30, 5);
        tick(c_SYNC + 3);
        #2;
        check_outputs("s100", 100, 30, 4, 0);
        check_val("s100_pulses", 32'(n_valid_seen - v0), 4);

        // Switch to 40/10; boundary period still reads 100/30.
        pwm(40, 10, 4);
        tick(c_SYNC + 3);
        #2;
        check_outputs("s40", 40, 10, 8, 0);

        // Timeout 500 with pin stuck high after 100/50 samples.
        cap_timeout = 32'd500;
        pwm(100, 50, 2);
        coe_pwm_in = 1'b1;
        tick(c_SYNC + 500);
        #2;
        check_val("to_early_flag", 32'(cap_timeout_flag), 0);
        tick(1);
        #2;
        check_outputs("to_set", 100, 50, 11, 1);
        tick(50);
        coe_pwm_in = 1'b0;
        tick(20);
        pwm(60, 20, 3);
        tick(c_SYNC + 3);
        #2;
        check_outputs("to_resume", 60, 20, 13, 1);

        // Clear on the very cycle a rise would complete a sample.
        cap_timeout = 32'd0;
        pwm(50, 20, 2);
        coe_pwm_in = 1'b1;
        tick(c_SYNC);
        cap_clear = 1'b1;
        v0 = n_valid_seen;
        tick(1);
        cap_clear = 1'b0;
        #2;
        check_outputs("clr", 0, 0, 0, 0);
        check_val("clr_valid", 32'(cap_valid), 0);
        tick(20 - c_SYNC - 1);
        coe_pwm_in = 1'b0;
        tick(30);
        pwm(50, 20, 3);
        tick(c_SYNC + 3);
        #2;
        check_outputs("clr_after", 50, 20, 2, 0);
        check_val("clr_pulses", 32'(n_valid_seen - v0), 2);

        // Enable dropped in the low phase for 20 cycles.
        pwm(80, 30, 2);
        coe_pwm_in = 1'b1;
        tick(30);
        coe_pwm_in = 1'b0;
        tick(10);
        cap_enable = 1'b0;
        v0 = n_valid_seen;
        tick(20);
        cap_enable = 1'b1;
        tick(40);
        #2;
        check_outputs("en_gap", 80, 30, 5, 0);
        check_val("en_gap_pulses", 32'(n_valid_seen - v0), 0);
        pwm(80, 30, 3);
        tick(c_SYNC + 3);
        #2;
        check_outputs("en_after", 80, 30, 7, 0);

        // Randomized segments; the per-cycle monitor carries the checking.
        for (int seg = 0; seg < 40; seg++) begin
            int p;
            int h;
            p = $urandom_range(60, 2);
            h = $urandom_range(p - 1, 1);
            pwm(p, h, $urandom_range(4, 1));
            case ($urandom_range(6, 0))
                0: begin cap_clear = 1'b1; tick(1); cap_clear = 1'b0; end
                1: begin cap_enable = 1'b0; tick($urandom_range(30, 1)); cap_enable = 1'b1; end
                2: cap_timeout = $urandom_range(80, 1);
                3: cap_timeout = 32'd0;
                4: begin coe_pwm_in = 1'b1; tick($urandom_range(150, 1)); coe_pwm_in = 1'b0; end
                default: tick($urandom_range(10, 0));
            endcase
        end

        // Asynchronous reset in the middle of a high phase.
        cap_timeout = 32'd0;
        pwm(30, 10, 2);
        coe_pwm_in = 1'b1;
        tick(c_SYNC + 5);
        @(posedge csi_clk);
        #3;
        rsi_reset_n = 1'b0;
        #1;
        check_outputs("arst", 0, 0, 0, 0);
        check_val("arst_valid", 32'(cap_valid), 0);
        coe_pwm_in = 1'b0;
        tick(2);
        rsi_reset_n = 1'b1;
        tick(5);
        pwm(2, 1, 6);
        tick(c_SYNC + 3);
        #2;
        check_outputs("min", 2, 1, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
